// File: rtl/fsm_bit_serializer.sv
// fsm_bit_serializer: valid/ready word in, one bit per clock out.
// A one-word holding register keeps back-to-back words gap-free.
module fsm_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;

  logic             accept;
  logic             at_last;
  logic [WIDTH-1:0] sreg_next;

  assign load_ready = reset & ~hold_full;
  assign accept     = load_valid & load_ready;
  assign at_last    = (cnt == LAST_CNT);

  // Shift toward whichever end drives x_out.
  always_comb begin
    sreg_next = sreg;
    if (MSB_FIRST) begin
      sreg_next = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      sreg_next = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            sreg  <= load_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        (state == SHIFT): begin
          if (!at_last) begin
            sreg <= sreg_next;
            cnt  <= cnt + CW'(1);
            if (accept) begin
              hold      <= load_data;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            sreg      <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
          end else if (accept) begin
            sreg <= load_data;
            cnt  <= '0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x_valid = (state == SHIFT);
  assign x_out   = x_valid &
                   (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign last    = x_valid & at_last;
  assign busy    = x_valid | hold_full;

endmodule
